// File: rtl/div_request_sequencer_if.sv
// Request and response channels between a client (master) and div_request_sequencer (slave).
interface div_request_sequencer_if #(
  parameter int WID0 = 32,
  parameter int WID1 = 16,
  parameter int TAGW = 4
) ();
  logic            req_valid;
  logic            req_ready;
  logic [WID0-1:0] req_num;
  logic [WID1-1:0] req_den;
  logic [TAGW-1:0] req_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [WID0-1:0] rsp_quot;
  logic [WID1-1:0] rsp_rem;
  logic [TAGW-1:0] rsp_tag;
  logic [1:0]      rsp_err;

  modport master (
    output req_valid, req_num, req_den, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_num, req_den, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_tag, rsp_err
  );
endinterface

// File: rtl/div_request_sequencer.sv
// Buffers tagged divide requests, feeds them one at a time to the multi-cycle divider,
// and returns tagged responses in order (local divide-by-zero, watchdog on completions).
module div_request_sequencer #(
  parameter int WID0    = 32,
  parameter int WID1    = 16,
  parameter int TAGW    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  div_request_sequencer_if.slave     bus,
  output logic [WID0-1:0]            dv_arg0,
  output logic [WID1-1:0]            dv_arg1,
  output logic                       dv_vldin,
  input  logic                       dv_busy,
  input  logic                       dv_vldout,
  input  logic [WID0-1:0]            dv_result,
  input  logic [WID1-1:0]            dv_remainder,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                 timeout_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WDW-1:0] WD_ONE   = WDW'(1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_d;

  logic [WID0-1:0] mem_num [DEPTH];
  logic [WID1-1:0] mem_den [DEPTH];
  logic [TAGW-1:0] mem_tag [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, count;
  logic            empty, full, push, pop;
  logic [WID0-1:0] head_num;
  logic [WID1-1:0] head_den;
  logic [TAGW-1:0] head_tag;
  logic [TAGW-1:0] held_tag;
  logic [WDW-1:0]  wd_cnt;
  logic            load_dz, load_issue, load_done, load_timeout;

  // Pointers carry an extra wrap bit so the difference is the true occupancy.
  assign count         = wr_ptr - rd_ptr;
  assign empty         = (count == '0);
  assign full          = (count == FULL_CNT);
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign fifo_count    = CW'(count);
  assign head_num      = mem_num[rd_ptr[AW-1:0]];
  assign head_den      = mem_den[rd_ptr[AW-1:0]];
  assign head_tag      = mem_tag[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_num[wr_ptr[AW-1:0]] <= bus.req_num;
      mem_den[wr_ptr[AW-1:0]] <= bus.req_den;
      mem_tag[wr_ptr[AW-1:0]] <= bus.req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // A new request is only taken while the response register is free, so nothing is overwritten.
  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    load_dz      = 1'b0;
    load_issue   = 1'b0;
    load_done    = 1'b0;
    load_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.rsp_valid) begin
          if (head_den == '0) begin
            pop     = 1'b1;
            load_dz = 1'b1;
          end else if (!dv_busy) begin
            pop        = 1'b1;
            load_issue = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (dv_vldout) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          load_timeout = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      dv_vldin      <= 1'b0;
      dv_arg0       <= '0;
      dv_arg1       <= '0;
      held_tag      <= '0;
      wd_cnt        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_quot  <= '0;
      bus.rsp_rem   <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_err   <= 2'd0;
      timeout_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      dv_vldin <= load_issue;
      if (load_issue) begin
        dv_arg0  <= head_num;
        dv_arg1  <= head_den;
        held_tag <= head_tag;
      end
      if (state == WAIT) wd_cnt <= wd_cnt + WD_ONE;
      else               wd_cnt <= '0;
      if (bus.rsp_valid && bus.rsp_ready) bus.rsp_valid <= 1'b0;
      if (load_dz) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_quot  <= '1;
        bus.rsp_rem   <= '0;
        bus.rsp_tag   <= head_tag;
        bus.rsp_err   <= 2'd1;
      end
      if (load_done) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_quot  <= dv_result;
        bus.rsp_rem   <= dv_remainder;
        bus.rsp_tag   <= held_tag;
        bus.rsp_err   <= 2'd0;
      end
      if (load_timeout) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_quot  <= '0;
        bus.rsp_rem   <= '0;
        bus.rsp_tag   <= held_tag;
        bus.rsp_err   <= 2'd2;
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/div_request_sequencer.md
Name: div_request_sequencer

Overview:
- Front-end stage that sits directly upstream of the multi-cycle unsigned divider. It also catches the divider's results.
- Accepts tagged divide requests over a valid/ready interface and buffers them in a FIFO.
- Issues requests one at a time to the divider's vldin/busy port and captures quotient/remainder on the divider's vldout.
- Returns tagged responses in order over a valid/ready interface. Division by zero is handled locally; a watchdog covers missing completions.

Parameters:
WID0, 32, dividend/quotient width (matches divider WID0)
WID1, 16, divisor/remainder width (matches divider WID1)
TAGW, 4, request tag width
DEPTH, 4, request FIFO entries; power of 2, >=2
TIMEOUT, 64, max WAIT cycles before declaring timeout; >=4

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  FIFO can accept (count<DEPTH)
req_num  in  WID0  dividend
req_den  in  WID1  divisor
req_tag  in  TAGW  request tag
dv_arg0  out  WID0  to divider arg0 (registered)
dv_arg1  out  WID1  to divider arg1 (registered)
dv_vldin  out  1  to divider vldin (registered, single-cycle pulse)
dv_busy  in  1  from divider busy
dv_vldout  in  1  from divider vldout
dv_result  in  WID0  from divider result
dv_remainder  in  WID1  from divider remainder
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_quot  out  WID0  quotient
rsp_rem  out  WID1  remainder
rsp_tag  out  TAGW  tag of the originating request
rsp_err  out  2  0=ok, 1=divide-by-zero, 2=timeout
fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy
timeout_cnt  out  8  saturating count of timeouts

Behaviour:
Reset:
- Every register clears: FIFO empty, fifo_count=0, req_ready=1, dv_vldin=0, dv_arg0=0, dv_arg1=0.
- rsp_valid=0, rsp_quot=0, rsp_rem=0, rsp_tag=0, rsp_err=0, timeout_cnt=0, state=IDLE.
- Reset mid-operation discards buffered and in-flight requests. No response is produced for them; the divider shares rst_n.

FIFO:
- Push when req_valid && req_ready.
- Read/write pointers carry one extra wrap bit. full = (count==DEPTH), so req_ready=0 when full.
- Pop occurs only in IDLE. Push and pop in the same cycle leave the count unchanged.
- A pop on a full FIFO raises req_ready in the next cycle, not the same cycle.

FSM states: IDLE, ISSUE, WAIT.
- IDLE, head divisor == 0, !rsp_valid:
  - Pop the head.
  - Load rsp_quot = all ones, rsp_rem = 0, rsp_tag = head tag, rsp_err = 1, rsp_valid = 1.
  - Stay in IDLE; the divider is not touched.
- IDLE, head divisor != 0, !rsp_valid, !dv_busy:
  - Pop the head.
  - Register dv_arg0/dv_arg1 and a held tag; set dv_vldin = 1.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle): dv_vldin high, divider samples the inputs. Next cycle dv_vldin = 0, clear the watchdog, go to WAIT.
- WAIT, dv_vldout high:
  - Capture dv_result/dv_remainder into rsp_quot/rsp_rem, held tag into rsp_tag, rsp_err = 0, rsp_valid = 1.
  - Go to IDLE.
  - dv_vldout is sampled only in WAIT; pulses in other states are ignored.
- WAIT, watchdog reaches TIMEOUT-1 with no vldout:
  - rsp_quot = 0, rsp_rem = 0, rsp_err = 2, rsp_valid = 1.
  - Increment timeout_cnt (saturates at 255). Go to IDLE.
- dv_vldout and timeout in the same cycle: vldout wins, rsp_err = 0.

Response register:
- rsp_valid holds, with rsp_* stable, until rsp_ready is sampled high; then it clears next cycle.
- IDLE never loads a new response while rsp_valid=1, so no response is ever overwritten or dropped.

Latency:
- Request accepted at edge E (cycle 0): FIFO non-empty cycle 1, ISSUE cycle 2, WAIT from cycle 3.
- For a divider answering one cycle after vldin, rsp_valid rises at cycle 4.
- Divide-by-zero: rsp_valid rises at cycle 2.
- Throughput: at most one request in flight; ordering is strictly FIFO.

Test Plan:
- After reset, push {num=100, den=7, tag=3}, rsp_ready=1 -> one response quot=14, rem=2, tag=3, err=0. Exactly one dv_vldin pulse is seen.
- Push den=0 (num=55, tag=1), then num=9, den=3, tag=2 -> tag1 response quot=all ones, rem=0, err=1, with no dv_vldin. Then tag2 response quot=3, rem=0, err=0, in order.
- Hold rsp_ready=0, push DEPTH+2 requests -> req_ready=0 once count hits 4. After a response is consumed, the remaining requests drain in tag order with no loss or duplication.
- Divider stub that never asserts vldout -> after TIMEOUT cycles in WAIT, response err=2 with the correct tag and timeout_cnt=1. The next request proceeds normally.
- dv_busy forced high while the FIFO is non-empty -> no dv_vldin until busy drops, then a single pulse. Push and pop in the same cycle keep fifo_count steady.
- Assert rst_n=0 during WAIT with 2 entries queued -> next cycle fifo_count=0, rsp_valid=0, dv_vldin=0. A late dv_vldout produces no response.
